regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (we/waddr/wdata) between two writeback sources of the multi-cycle MIPS core: the main datapath writeback (port 0) and long-latency units such as mul/div or CP0 moves (port 1). Each source hands writes in over a valid/ready handshake into a one-entry holding slot. The arbiter drains the slots into the register file one write per cycle with fixed priority, a starvation guard and same-address ordering. It exports a pending-write mask so the control FSM can stall reads of registers whose writes are still in flight.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/wb_slot.sv | 69 ++++++
 rtl/regfile_wb_arbiter.sv | 159 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
package regfile_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    localparam logic [RF_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam int WB_PORT_CORE = 0;
    localparam int WB_PORT_LONG = 1;
    localparam int WB_NUM_PORTS = 2;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two writeback request ports, the register-file write port
// and the pending-write mask. The arbiter sits on the slave side.
interface regfile_wb_arbiter_if
#(
    parameter int ADDR_W = regfile_pkg::RF_ADDR_W,
    parameter int DATA_W = regfile_pkg::RF_DATA_W
);

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;

    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [31:0]       pending_mask;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  pending_mask
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_we, rf_waddr, rf_wdata,
        output pending_mask
    );

endinterface

// File: rtl/wb_slot.sv
// Single-entry writeback holding slot. A load in the same cycle as a clear
// wins, so a slot that issues can be refilled at the same edge. The older
// flag is cleared whenever the slot loads and is set by the arbiter when the
// other slot loads behind it.
module wb_slot
#(
    parameter int ADDR_W = regfile_pkg::RF_ADDR_W,
    parameter int DATA_W = regfile_pkg::RF_DATA_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              mark_older,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              older
);

    logic              full_reg,  full_next;
    logic [ADDR_W-1:0] addr_reg,  addr_next;
    logic [DATA_W-1:0] data_reg,  data_next;
    logic              older_reg, older_next;

    // Next-state: issue empties, a younger arrival marks us older, load refills.
    always_comb begin
        full_next  = full_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        older_next = older_reg;
        if (clear) begin
            full_next = 1'b0;
        end
        if (mark_older) begin
            older_next = 1'b1;
        end
        if (load) begin
            full_next  = 1'b1;
            addr_next  = load_addr;
            data_next  = load_data;
            older_next = 1'b0;
        end
    end

    // Slot registers; reset discards any buffered write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_reg  <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            older_reg <= 1'b0;
        end else begin
            full_reg  <= full_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            older_reg <= older_next;
        end
    end

    assign full  = full_reg;
    assign addr  = addr_reg;
    assign data  = data_reg;
    assign older = older_reg;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port. Port 0
// (core datapath) normally wins; port 1 (long-latency units) wins after
// MAX_WAIT consecutive denials, and same-address writes drain oldest first.
// All outputs are derived from slot state only.
module regfile_wb_arbiter
#(
    parameter int DATA_W   = regfile_pkg::RF_DATA_W,
    parameter int ADDR_W   = regfile_pkg::RF_ADDR_W,
    parameter int MAX_WAIT = 4
)
(
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    import regfile_pkg::*;

    localparam int         NPORT      = WB_NUM_PORTS;
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [NPORT-1:0]  req_valid;
    logic [ADDR_W-1:0] req_addr   [NPORT];
    logic [DATA_W-1:0] req_data   [NPORT];

    logic [NPORT-1:0]  slot_ready;
    logic [NPORT-1:0]  slot_load;
    logic [NPORT-1:0]  slot_mark_older;
    logic [NPORT-1:0]  slot_full;
    logic [NPORT-1:0]  slot_older;
    logic [ADDR_W-1:0] slot_addr  [NPORT];
    logic [DATA_W-1:0] slot_data  [NPORT];

    logic [NPORT-1:0]  grant;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [31:0]       pending_mask;

    assign req_valid[WB_PORT_CORE] = bus.req0_valid;
    assign req_addr[WB_PORT_CORE]  = bus.req0_addr;
    assign req_data[WB_PORT_CORE]  = bus.req0_data;
    assign req_valid[WB_PORT_LONG] = bus.req1_valid;
    assign req_addr[WB_PORT_LONG]  = bus.req1_addr;
    assign req_data[WB_PORT_LONG]  = bus.req1_data;

    assign bus.req0_ready = slot_ready[WB_PORT_CORE];
    assign bus.req1_ready = slot_ready[WB_PORT_LONG];

    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_slot
            // Ready never looks at valid: empty, or draining this cycle.
            assign slot_ready[gi] = !slot_full[gi] || grant[gi];
            // Writes to the zero register complete the handshake but are dropped.
            assign slot_load[gi]  = req_valid[gi] && slot_ready[gi] &&
                                    (req_addr[gi] != ADDR_W'(ZERO_REG));
            // A slot that stays full while the other one loads is now the older.
            assign slot_mark_older[gi] = slot_load[NPORT-1-gi] &&
                                         slot_full[gi] && !grant[gi];

            wb_slot #(
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_slot (
                .clk        (clk),
                .reset      (reset),
                .load       (slot_load[gi]),
                .clear      (grant[gi]),
                .mark_older (slot_mark_older[gi]),
                .load_addr  (req_addr[gi]),
                .load_data  (req_data[gi]),
                .full       (slot_full[gi]),
                .addr       (slot_addr[gi]),
                .data       (slot_data[gi]),
                .older      (slot_older[gi])
            );
        end
    endgenerate

    // Grant: sole occupant wins; same address drains oldest (tie to core);
    // otherwise core wins unless the long port has waited out its budget.
    always_comb begin
        grant = '0;
        if (slot_full[WB_PORT_CORE] && !slot_full[WB_PORT_LONG]) begin
            grant[WB_PORT_CORE] = 1'b1;
        end else if (!slot_full[WB_PORT_CORE] && slot_full[WB_PORT_LONG]) begin
            grant[WB_PORT_LONG] = 1'b1;
        end else if (slot_full[WB_PORT_CORE] && slot_full[WB_PORT_LONG]) begin
            if (slot_addr[WB_PORT_CORE] == slot_addr[WB_PORT_LONG]) begin
                if (slot_older[WB_PORT_LONG]) begin
                    grant[WB_PORT_LONG] = 1'b1;
                end else begin
                    grant[WB_PORT_CORE] = 1'b1;
                end
            end else if (wait_cnt_reg == WAIT_LIMIT) begin
                grant[WB_PORT_LONG] = 1'b1;
            end else begin
                grant[WB_PORT_CORE] = 1'b1;
            end
        end
    end

    // Write port mux: zero on idle cycles so downstream sees clean values.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (grant[WB_PORT_CORE]) begin
            rf_we    = 1'b1;
            rf_waddr = slot_addr[WB_PORT_CORE];
            rf_wdata = slot_data[WB_PORT_CORE];
        end else if (grant[WB_PORT_LONG]) begin
            rf_we    = 1'b1;
            rf_waddr = slot_addr[WB_PORT_LONG];
            rf_wdata = slot_data[WB_PORT_LONG];
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            if (gi == 0) begin : g_zero
                assign pending_mask[gi] = 1'b0;
            end else begin : g_bit
                assign pending_mask[gi] =
                    (slot_full[WB_PORT_CORE] && (slot_addr[WB_PORT_CORE] == ADDR_W'(gi))) ||
                    (slot_full[WB_PORT_LONG] && (slot_addr[WB_PORT_LONG] == ADDR_W'(gi)));
            end
        end
    endgenerate

    // Starvation counter: counts consecutive denied cycles of the long port.
    always_comb begin
        wait_cnt_next = 4'd0;
        if (slot_full[WB_PORT_LONG] && !grant[WB_PORT_LONG]) begin
            if (wait_cnt_reg == WAIT_LIMIT) begin
                wait_cnt_next = wait_cnt_reg;
            end else begin
                wait_cnt_next = wait_cnt_reg + 4'd1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_reg <= 4'd0;
        end else begin
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    assign bus.rf_we        = rf_we;
    assign bus.rf_waddr     = rf_waddr;
    assign bus.rf_wdata     = rf_wdata;
    assign bus.pending_mask = pending_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// timestamp-based behavioural model.
module tb_regfile_wb_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        int          c;
    } ent_t;

    logic clk;
    logic reset;

    regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_wb_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural model: slot contents stamped with the cycle they loaded.
    logic        m_full  [2];
    logic [4:0]  m_addr  [2];
    logic [31:0] m_data  [2];
    int          m_stamp [2];
    int          m_wait;

    // Observations from the most recent cycle
    logic        obs_we, obs_rdy0, obs_rdy1;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data, obs_mask;
    ent_t        log_q[$];
    logic [31:0] dut_rf [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int s = 0; s < 2; s++) begin
            m_full[s]  = 1'b0;
            m_addr[s]  = '0;
            m_data[s]  = '0;
            m_stamp[s] = 0;
        end
        m_wait = 0;
    endfunction

    function automatic void model_grant(output logic g0, output logic g1);
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1]) begin
                if (m_stamp[1] < m_stamp[0]) g1 = 1'b1;
                else                         g0 = 1'b1;
            end else if (m_wait >= MAX_WAIT) begin
                g1 = 1'b1;
            end else begin
                g0 = 1'b1;
            end
        end else begin
            g0 = m_full[0];
            g1 = m_full[1];
        end
    endfunction

    task automatic cycle(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        logic        g0, g1, er0, er1, ewe;
        logic [4:0]  ea;
        logic [31:0] ed, em;
        @(negedge clk);
        bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
        #1;
        model_grant(g0, g1);
        er0 = !m_full[0] || g0;
        er1 = !m_full[1] || g1;
        ewe = g0 || g1;
        ea  = g0 ? m_addr[0] : (g1 ? m_addr[1] : 5'd0);
        ed  = g0 ? m_data[0] : (g1 ? m_data[1] : 32'd0);
        em  = '0;
        for (int s = 0; s < 2; s++) if (m_full[s]) em[m_addr[s]] = 1'b1;
        em[0] = 1'b0;

        obs_we   = bus.rf_we;   obs_addr = bus.rf_waddr; obs_data = bus.rf_wdata;
        obs_mask = bus.pending_mask;
        obs_rdy0 = bus.req0_ready; obs_rdy1 = bus.req1_ready;
        chk("ready0", {63'd0, obs_rdy0}, {63'd0, er0});
        chk("ready1", {63'd0, obs_rdy1}, {63'd0, er1});
        chk("rf_we",  {63'd0, obs_we},   {63'd0, ewe});
        chk("rf_waddr", {59'd0, obs_addr}, {59'd0, ea});
        chk("rf_wdata", {32'd0, obs_data}, {32'd0, ed});
        chk("pending_mask", {32'd0, obs_mask}, {32'd0, em});
        if (obs_we) begin
            log_q.push_back('{a: obs_addr, d: obs_data, c: cyc});
            dut_rf[obs_addr] = obs_data;
        end
        $display("[TB] cyc %0d in0=%0b/%0d in1=%0b/%0d rdy=%0b%0b we=%0b addr=%0d data=%0h mask=%0h",
                 cyc, v0, a0, v1, a1, obs_rdy0, obs_rdy1, obs_we, obs_addr, obs_data, obs_mask);

        // Advance the model to the state after the coming edge.
        if (m_full[1] && !g1) m_wait = (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
        else                  m_wait = 0;
        if (g0) m_full[0] = 1'b0;
        if (g1) m_full[1] = 1'b0;
        if (v0 && er0 && a0 != 5'd0) begin
            m_full[0] = 1'b1; m_addr[0] = a0; m_data[0] = d0; m_stamp[0] = cyc;
        end
        if (v1 && er1 && a1 != 5'd0) begin
            m_full[1] = 1'b1; m_addr[1] = a1; m_data[1] = d1; m_stamp[1] = cyc;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        reset = 1'b1;
        #1;
        model_clear();
        chk("reset_rf_we", {63'd0, bus.rf_we}, 64'd0);
        chk("reset_mask", {32'd0, bus.pending_mask}, 64'd0);
        chk("reset_ready0", {63'd0, bus.req0_ready}, 64'd1);
        chk("reset_ready1", {63'd0, bus.req1_ready}, 64'd1);
        $display("[TB] reset applied at cycle %0d", cyc);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p1_at;
        logic [4:0] resume_addr;
        reset = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        for (int i = 0; i < 32; i++) dut_rf[i] = '0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // Reset with both slots full: nothing stale may be committed afterwards.
        cycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        do_reset();
        log_q.delete();
        idle(3);
        chk("reset_no_stale", 64'(log_q.size()), 64'd0);

        // Single write.
        cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(1);
        chk("single_we", {63'd0, obs_we}, 64'd1);
        chk("single_addr", {59'd0, obs_addr}, 64'd3);
        chk("single_data", {32'd0, obs_data}, 64'hDEADBEEF);
        chk("single_mask", {32'd0, obs_mask}, 64'h8);
        idle(1);
        chk("single_mask_after", {32'd0, obs_mask}, 64'd0);

        // Starvation guard: port 0 streams to r5, port 1 holds r7.
        cycle(1'b1, 5'd5, 32'd100, 1'b1, 5'd7, 32'h7);
        p1_at = -1;
        resume_addr = '0;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 5'd5, 32'(100 + k), 1'b0, 5'd0, 32'd0);
            if (obs_we && obs_addr == 5'd7 && p1_at < 0) begin
                p1_at = k;
                chk("starve_data", {32'd0, obs_data}, 64'h7);
            end
            if (k == 6) resume_addr = obs_addr;
        end
        chk("starve_p1_cycle", 64'(p1_at), 64'd5);
        chk("starve_resume", {59'd0, resume_addr}, 64'd5);
        idle(3);

        // Same address, port 1 first.
        log_q.delete();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'd1);
        cycle(1'b1, 5'd9, 32'd2, 1'b0, 5'd0, 32'd0);
        idle(3);
        chk("order_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            chk("order_first", {32'd0, log_q[0].d}, 64'd1);
            chk("order_second", {32'd0, log_q[1].d}, 64'd2);
        end
        chk("order_r9", {32'd0, dut_rf[9]}, 64'd2);

        // Same address, same edge: port 0 then port 1.
        log_q.delete();
        cycle(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        idle(3);
        chk("tie_count", 64'(log_q.size()), 64'd2);
        if (log_q.size() == 2) begin
            chk("tie_first", {32'd0, log_q[0].d}, 64'hA);
            chk("tie_second", {32'd0, log_q[1].d}, 64'hB);
        end

        // Port 1 becomes older when port 0 refills behind it on the same register.
        log_q.delete();
        cycle(1'b1, 5'd4, 32'hA1, 1'b1, 5'd6, 32'hB2);
        cycle(1'b1, 5'd6, 32'hC3, 1'b0, 5'd0, 32'd0);
        idle(4);
        chk("older_count", 64'(log_q.size()), 64'd3);
        if (log_q.size() == 3) begin
            chk("older_w0", {27'd0, log_q[0].a, log_q[0].d}, {27'd0, 5'd4, 32'hA1});
            chk("older_w1", {27'd0, log_q[1].a, log_q[1].d}, {27'd0, 5'd6, 32'hB2});
            chk("older_w2", {27'd0, log_q[2].a, log_q[2].d}, {27'd0, 5'd6, 32'hC3});
        end

        // Zero register on port 1.
        log_q.delete();
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h123);
        chk("zero_ready", {63'd0, obs_rdy1}, 64'd1);
        idle(1);
        chk("zero_we", {63'd0, obs_we}, 64'd0);
        chk("zero_mask", {32'd0, obs_mask}, 64'd0);
        idle(1);
        chk("zero_log", 64'(log_q.size()), 64'd0);

        // Back-to-back on port 0.
        log_q.delete();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'd0);
            chk("b2b_ready", {63'd0, obs_rdy0}, 64'd1);
        end
        idle(2);
        chk("b2b_count", 64'(log_q.size()), 64'd8);
        if (log_q.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                chk("b2b_addr", {59'd0, log_q[j].a}, 64'(j + 1));
                chk("b2b_data", {32'd0, log_q[j].d}, 64'((j + 1) * 16));
                chk("b2b_consec", 64'(log_q[j].c), 64'(log_q[0].c + j));
            end
        end

        // Randomized traffic with small address range to force collisions.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            end
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
